attribute_symbol_sequencer: RTL
===============================

# attribute_symbol_sequencer

Sits directly upstream of the attribute decompressor in the LiDAR decoder. Accepts the entropy decoder's serial symbol stream, pairs symbols into (prediction mode, residual) and keeps the last K reconstructed attributes as the neighbour set. Presents both to the decompressor, waits its fixed pipeline latency, then writes the returned final attribute back into the neighbour history. It also enforces frame boundaries and flags out-of-range modes.

## Interface
- SYMBOL_WIDTH, 8, width of one decoded symbol
- ATTR_WIDTH, 8, attribute width
- K, 4, number of neighbour attributes held
- MODE_WIDTH, 3, mode field, taken from symbol bits [MODE_WIDTH-1:0]
- ATTR_LATENCY, 1, cycles from pair issue to valid `final_attribute` (range 1..15)
- POINT_CNT_WIDTH, 16, width of the per-frame point counter

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- sym_valid  in  1  symbol available
- sym_ready  out  1  sequencer accepts symbol this cycle
- sym_data  in  SYMBOL_WIDTH  symbol value
- sym_last  in  1  symbol is the last of the frame
- decoded_symbols  out  [1:0] x SYMBOL_WIDTH  [0] = mode symbol, [1] = residual symbol (registered)
- neighboring_attributes  out  [K-1:0] x ATTR_WIDTH  history, [0] = most recent
- pair_valid  out  1  one-cycle strobe, pair presented
- final_attribute  in  ATTR_WIDTH  decompressor result, fed back
- mode_error  out  1  one-cycle strobe: mode > K or mode references an absent neighbour
- frame_error  out  1  one-cycle strobe: `sym_last` on a mode symbol
- frame_done  out  1  one-cycle strobe after the last point of the frame is written back
- point_count  out  POINT_CNT_WIDTH  points completed in the current frame
- err_count  out  8  saturating count of `mode_error` plus `frame_error`

## Operation
- **FSM states:** S_MODE, S_RESID, S_ISSUE, S_WAIT.
- **S_MODE:**
  - `sym_ready` = 1.
  - On `sym_valid`, capture `sym_data` into `decoded_symbols[0]` and go to S_RESID.
  - If `sym_last` is also 1: pulse `frame_error`, discard the symbol, clear the frame (history, `hist_count`, `point_count`), stay in S_MODE.
- **S_RESID:**
  - `sym_ready` = 1.
  - On `sym_valid`, capture `sym_data` into `decoded_symbols[1]`, latch `sym_last` into `frame_last`, go to S_ISSUE.
- **S_ISSUE:**
  - `sym_ready` = 0, `pair_valid` = 1.
  - Load `lat_cnt` with ATTR_LATENCY and go to S_WAIT.
  - `mode_error` pulses if mode > K, or if mode ≥ 1 and mode > `hist_count`.
  - The pair is still issued on error; the decompressor handles the actual prediction.
- **S_WAIT:**
  - `sym_ready` = 0; `lat_cnt` decrements each cycle.
  - On the cycle where `lat_cnt` = 1:
    - Shift the history: entry[i] ← entry[i-1], entry[0] ← `final_attribute`.
    - `hist_count` increments, saturating at K.
    - `point_count` increments, wrapping.
    - Go to S_MODE.
  - If `frame_last` is set, the clear overrides the shift in that same cycle: history = 0, `hist_count` = 0, `point_count` = 0, pulse `frame_done`.
- **Stable outputs:** `decoded_symbols` and `neighboring_attributes` hold their values from capture until the next capture or clear.
- **err_count:** increments on each error strobe and saturates at 255. `mode_error` and `frame_error` cannot coincide.

## Timing
- **Reset values (first edge with `rst_n` = 0):**
  - state = S_MODE.
  - All outputs 0: `decoded_symbols`, history, counters, all strobes.
  - `sym_ready` = 1 from the first cycle after reset release.
- **Reset mid-operation:** aborts any pair in flight; nothing is written back.
- **Throughput:** one point per 3 + ATTR_LATENCY cycles when symbols arrive back-to-back (default 4).
- **Write-back timing:** with `pair_valid` in cycle T, `final_attribute` is sampled at the end of cycle T+ATTR_LATENCY. Updated neighbours are visible from cycle T+ATTR_LATENCY+1.
- **Handshake:** `sym_ready` is a registered function of state and does not depend on `sym_valid`. A symbol transfers only when both are 1.
- **Upstream stall:** S_MODE and S_RESID hold indefinitely with outputs unchanged.

## Structure
- **Shared package `attr_dec_pkg`:**
  - state enum `seq_state_t`
  - default constants SYMBOL_WIDTH, ATTR_WIDTH, K, MODE_WIDTH
  - mode field extract function
- **Sub-module `attr_history_shift`:**
  - K × ATTR_WIDTH shift register with shift, sync clear, `hist_count` saturation.
  - Clear has priority over shift.

## Test plan
- **Reset:** reset, then a single pair {mode=0, res=5} with `final_attribute` = 0x2A → `pair_valid` in cycle 3 after release, `neighboring_attributes[0]` = 0x2A, `point_count` = 1, `hist_count` = 1.
- **History fill:** 5 pairs returning 1, 2, 3, 4, 5 (K=4) → neighbours [0..3] = 5, 4, 3, 2; `hist_count` saturated at 4; `point_count` = 5.
- **Mode errors:** mode=2 as the first point of a frame → `mode_error` pulse, `err_count` = 1, pair still issued. mode=5 with full history → `mode_error`.
- **Frame end:** `sym_last` on a residual → after write-back, `frame_done` pulses; history and `point_count` read 0 the next cycle.
- **Frame error:** `sym_last` on a mode symbol → `frame_error` pulse, no `pair_valid`, frame cleared.
- **Back-pressure and reset:** random `sym_valid` gaps, and ATTR_LATENCY=3 → symbols are never accepted in S_ISSUE or S_WAIT, 6-cycle point spacing. `rst_n` low during S_WAIT → no write-back, all outputs 0.

Source files
------------

// File: rtl/attr_dec_pkg.sv
// Shared definitions for the attribute decode path.
//   seq_state_t : sequencer FSM states
//   DEF_*       : default widths / depth used by the decoder blocks
//   mode_field  : extracts the prediction-mode field from a symbol
package attr_dec_pkg;

  localparam int DEF_SYMBOL_WIDTH = 8;
  localparam int DEF_ATTR_WIDTH   = 8;
  localparam int DEF_K            = 4;
  localparam int DEF_MODE_WIDTH   = 3;

  typedef enum logic [1:0] {
    S_MODE  = 2'd0,
    S_RESID = 2'd1,
    S_ISSUE = 2'd2,
    S_WAIT  = 2'd3
  } seq_state_t;

  // Symbol is passed zero-extended to 32 bits so the helper works for any
  // symbol width up to 32; the low mode_width bits are the mode.
  function automatic logic [31:0] mode_field(input logic [31:0] sym, input int mode_width);
    logic [31:0] mask;
    mask = (32'd1 << mode_width) - 32'd1;
    return sym & mask;
  endfunction

endpackage

// File: rtl/attr_history_shift.sv
// Neighbour history: K entries of ATTR_WIDTH, entry 0 is the most recent.
//   clk, rst_n  : clock, synchronous active-low reset
//   shift_en    : push din into entry 0, older entries move up by one
//   clear       : synchronous clear of history and count (wins over shift)
//   din         : attribute to push
//   hist        : history contents
//   hist_count  : number of valid entries, saturates at K
module attr_history_shift
  import attr_dec_pkg::*;
#(
  parameter int ATTR_WIDTH = DEF_ATTR_WIDTH,
  parameter int K          = DEF_K
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          shift_en,
  input  logic                          clear,
  input  logic [ATTR_WIDTH-1:0]         din,
  output logic [K-1:0][ATTR_WIDTH-1:0]  hist,
  output logic [$clog2(K+1)-1:0]        hist_count
);

  localparam int HCW = $clog2(K + 1);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      hist       <= '0;
      hist_count <= '0;
    end else if (shift_en) begin
      hist[0] <= din;
      for (int i = 1; i < K; i++) begin
        hist[i] <= hist[i-1];
      end
      if (hist_count != HCW'(K)) begin
        hist_count <= HCW'(hist_count + 1'b1);
      end
    end
  end

endmodule

// File: rtl/attribute_symbol_sequencer.sv
// Pairs the entropy decoder's symbol stream into (mode, residual), presents
// the pair plus the neighbour history to the attribute decompressor, waits
// its fixed latency and writes the returned attribute back into the history.
// Also enforces frame boundaries and counts mode / framing errors.
//   clk, rst_n             : clock, synchronous active-low reset
//   sym_valid/ready/data/last : symbol stream handshake
//   decoded_symbols        : [0] mode symbol, [1] residual symbol
//   neighboring_attributes : history, [0] most recent
//   pair_valid             : one-cycle strobe when a pair is presented
//   final_attribute        : decompressor result fed back
//   mode_error, frame_error, frame_done : one-cycle strobes
//   point_count            : points completed in the current frame
//   err_count              : saturating error count
module attribute_symbol_sequencer
  import attr_dec_pkg::*;
#(
  parameter int SYMBOL_WIDTH    = DEF_SYMBOL_WIDTH,
  parameter int ATTR_WIDTH      = DEF_ATTR_WIDTH,
  parameter int K               = DEF_K,
  parameter int MODE_WIDTH      = DEF_MODE_WIDTH,
  parameter int ATTR_LATENCY    = 1,
  parameter int POINT_CNT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sym_valid,
  output logic                          sym_ready,
  input  logic [SYMBOL_WIDTH-1:0]       sym_data,
  input  logic                          sym_last,
  output logic [1:0][SYMBOL_WIDTH-1:0]  decoded_symbols,
  output logic [K-1:0][ATTR_WIDTH-1:0]  neighboring_attributes,
  output logic                          pair_valid,
  input  logic [ATTR_WIDTH-1:0]         final_attribute,
  output logic                          mode_error,
  output logic                          frame_error,
  output logic                          frame_done,
  output logic [POINT_CNT_WIDTH-1:0]    point_count,
  output logic [7:0]                    err_count
);

  seq_state_t                 state_reg;
  logic [3:0]                 lat_cnt_reg;
  logic                       frame_last_reg;
  logic [$clog2(K+1)-1:0]     hist_count;
  logic                       sym_xfer;
  logic                       write_back;
  logic                       hist_clear;
  logic [31:0]                mode_val;
  logic                       mode_bad;

  assign sym_xfer   = sym_valid && sym_ready;
  assign write_back = (state_reg == S_WAIT) && (lat_cnt_reg == 4'd1);
  // Frame clear comes either from a misplaced sym_last on a mode symbol or
  // from completing the last point of the frame (overrides the shift).
  assign hist_clear = (write_back && frame_last_reg) ||
                      ((state_reg == S_MODE) && sym_xfer && sym_last);

  assign mode_val = mode_field(32'(decoded_symbols[0]), MODE_WIDTH);
  assign mode_bad = (mode_val > 32'(K)) ||
                    ((mode_val >= 32'd1) && (mode_val > 32'(hist_count)));

  attr_history_shift #(
    .ATTR_WIDTH (ATTR_WIDTH),
    .K          (K)
  ) u_hist (
    .clk        (clk),
    .rst_n      (rst_n),
    .shift_en   (write_back),
    .clear      (hist_clear),
    .din        (final_attribute),
    .hist       (neighboring_attributes),
    .hist_count (hist_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= S_MODE;
      sym_ready       <= 1'b0;
      decoded_symbols <= '0;
      pair_valid      <= 1'b0;
      mode_error      <= 1'b0;
      frame_error     <= 1'b0;
      frame_done      <= 1'b0;
      point_count     <= '0;
      err_count       <= '0;
      frame_last_reg  <= 1'b0;
      lat_cnt_reg     <= '0;
    end else begin
      pair_valid  <= 1'b0;
      mode_error  <= 1'b0;
      frame_error <= 1'b0;
      frame_done  <= 1'b0;
      case (state_reg)
        S_MODE: begin
          sym_ready <= 1'b1;
          if (sym_xfer) begin
            if (sym_last) begin
              // Frame ended on a mode symbol: drop it and restart the frame.
              frame_error <= 1'b1;
              point_count <= '0;
              if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end else begin
              decoded_symbols[0] <= sym_data;
              state_reg          <= S_RESID;
            end
          end
        end
        S_RESID: begin
          if (sym_xfer) begin
            decoded_symbols[1] <= sym_data;
            frame_last_reg     <= sym_last;
            state_reg          <= S_ISSUE;
            sym_ready          <= 1'b0;
            // Strobes registered here so they are high during S_ISSUE.
            pair_valid         <= 1'b1;
            if (mode_bad) begin
              mode_error <= 1'b1;
              if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end
          end
        end
        S_ISSUE: begin
          lat_cnt_reg <= 4'(ATTR_LATENCY);
          state_reg   <= S_WAIT;
        end
        S_WAIT: begin
          lat_cnt_reg <= lat_cnt_reg - 4'd1;
          if (lat_cnt_reg == 4'd1) begin
            state_reg <= S_MODE;
            sym_ready <= 1'b1;
            if (frame_last_reg) begin
              point_count    <= '0;
              frame_done     <= 1'b1;
              frame_last_reg <= 1'b0;
            end else begin
              point_count <= point_count + 1'b1;
            end
          end
        end
        default: state_reg <= S_MODE;
      endcase
    end
  end

endmodule
